// File: rtl/contador_mp.sv
// Programmable-modulus up/down counter with wrap/saturate, parallel load,
// fraction markers and a registered overflow pulse for cascading.
module contador_mp #(
  parameter int unsigned N = 7,
  parameter int unsigned M = 100
) (
  input  logic         clock,
  input  logic         zera_n,
  input  logic         zera_s,
  input  logic         conta,
  input  logic         desce,
  input  logic         satura,
  input  logic         carrega,
  input  logic [N-1:0] dado,
  input  logic         define_m,
  input  logic [N:0]   modulo,
  output logic [N-1:0] Q,
  output logic [N:0]   m_atual,
  output logic         fim,
  output logic         zero,
  output logic         meio,
  output logic         quarto,
  output logic         estouro
);

  if (M < 2 || 64'(M) > (64'(1) << N)) begin : g_bad_m
    $error("contador_mp: M must lie in 2..2^N");
  end

  localparam logic [N:0] MRst   = (N+1)'(M);
  localparam logic [N:0] ModMin = (N+1)'(2);
  localparam logic [N:0] ModMax = {1'b1, {N{1'b0}}};
  localparam logic [N:0] One    = (N+1)'(1);

  logic [N-1:0] q_q, q_d;
  logic [N:0]   m_q, m_d;
  logic         est_q, est_d;

  logic [N:0]   q_ext, dado_ext;
  logic [N:0]   m_clamped, m_eff, m_last, m_eff_last;

  assign q_ext    = {1'b0, q_q};
  assign dado_ext = {1'b0, dado};

  always_comb begin
    m_clamped = modulo;
    if (modulo < ModMin) begin
      m_clamped = ModMin;
    end else if (modulo > ModMax) begin
      m_clamped = ModMax;
    end
  end

  // Load clamps against the modulus that will be active after this edge.
  assign m_eff      = define_m ? m_clamped : m_q;
  assign m_last     = m_q - One;
  assign m_eff_last = m_eff - One;

  always_comb begin
    q_d   = q_q;
    m_d   = m_q;
    est_d = 1'b0;
    if (zera_s) begin
      q_d = '0;
      if (define_m) begin
        m_d = m_clamped;
      end
    end else if (define_m || carrega) begin
      if (define_m) begin
        m_d = m_clamped;
      end
      if (carrega) begin
        q_d = (dado_ext > m_eff_last) ? m_eff_last[N-1:0] : dado;
      end else if (q_ext >= m_clamped) begin
        q_d = '0;
      end
    end else if (conta) begin
      if (!desce) begin
        if (q_ext < m_last) begin
          q_d = q_q + N'(1);
        end else begin
          est_d = 1'b1;
          if (!satura) begin
            q_d = '0;
          end
        end
      end else begin
        if (q_q != '0) begin
          q_d = q_q - N'(1);
        end else begin
          est_d = 1'b1;
          if (!satura) begin
            q_d = m_last[N-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!zera_n) begin
      q_q   <= '0;
      m_q   <= MRst;
      est_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      m_q   <= m_d;
      est_q <= est_d;
    end
  end

  assign Q       = q_q;
  assign m_atual = m_q;
  assign estouro = est_q;

  assign fim    = (q_ext == m_last);
  assign zero   = (q_q == '0);
  assign meio   = (q_ext == ((m_q >> 1) - One));
  assign quarto = (m_q >= (N+1)'(4)) && (q_ext == ((m_q >> 2) - One));

endmodule

// File: doc/contador_mp.md
# contador_mp

Programmable-modulus up/down counter: the parametrised successor of the fixed-modulus counter used throughout the lab datapaths (timers, address generators, debounce windows).
- Modulus is changed at run time; the parameter only sets its reset value.
- Counts up or down, supports parallel load, and can wrap or saturate.
- Fraction markers (fim, meio, quarto, zero) are derived from the active modulus.
- Registered overflow pulse for cascading into a higher-order stage.

## Interface
Parameters:
- N, default 7: counter width in bits.
- M, default 100: modulus after reset. Legal range 2..2^N; checked at elaboration.

Ports:
- clock, in, 1: single clock; all state changes on the rising edge.
- zera_n, in, 1: reset, synchronous, active-low. Highest priority.
- zera_s, in, 1: synchronous clear of Q only. Modulus is kept.
- conta, in, 1: count enable.
- desce, in, 1: direction. 0 = up, 1 = down.
- satura, in, 1: limit mode. 0 = wrap, 1 = saturate at limits.
- carrega, in, 1: parallel load of Q from dado.
- dado, in, N: load value.
- define_m, in, 1: modulus write strobe.
- modulo, in, N+1: new modulus value.
- Q, out, N: count value, registered.
- m_atual, out, N+1: active modulus register.
- fim, out, 1: combinational. 1 when Q == m_atual-1.
- zero, out, 1: combinational. 1 when Q == 0.
- meio, out, 1: combinational. 1 when Q == (m_atual>>1)-1.
- quarto, out, 1: combinational. 1 when Q == (m_atual>>2)-1 and m_atual >= 4; otherwise always 0.
- estouro, out, 1: registered one-cycle pulse (see Operation).

## Operation
Register update priority, evaluated each rising edge:
1. zera_n=0: Q<=0, m_atual<=M, estouro<=0. All other inputs are ignored.
2. zera_s=1: Q<=0, estouro<=0. A simultaneous define_m still updates m_atual.
3. define_m and/or carrega:
   - define_m: the new modulus m' is modulo clamped to [2, 2^N]; m_atual<=m'.
   - carrega: Q<=min(dado, m_eff-1), where m_eff is m' if define_m is also asserted, else m_atual.
   - define_m without carrega: if Q >= m', then Q<=0; otherwise Q holds.
   - conta is ignored this cycle. estouro<=0.
4. conta=1, up (desce=0):
   - Q < m_atual-1: Q<=Q+1.
   - Q == m_atual-1 and satura=0: Q<=0, estouro<=1.
   - Q == m_atual-1 and satura=1: Q holds, estouro<=1.
5. conta=1, down (desce=1):
   - Q > 0: Q<=Q-1.
   - Q == 0 and satura=0: Q<=m_atual-1, estouro<=1.
   - Q == 0 and satura=1: Q holds, estouro<=1.
6. Otherwise: Q holds, estouro<=0.

Arithmetic and invariants:
- All comparisons are unsigned, done at N+1 bits.
- Invariant: Q < m_atual at all times after reset.
- m_atual = 2^N: Q uses the full range, and the up-wrap goes from 2^N-1 to 0.
- desce and satura may change in any cycle. They take effect on the same edge.

## Timing
- Q, m_atual and estouro are registered, with 1-cycle latency from input to output.
- fim, zero, meio and quarto settle combinationally from Q and m_atual in the same cycle. No extra latency.
- estouro is high for exactly the cycle after a limit-crossing edge.
  - If conta stays high at a saturated limit, estouro stays high on every one of those cycles.
- Reset values: Q=0, m_atual=M, estouro=0, zero=1, fim=(M==1 ? 1 : 0)=0. meio and quarto follow from M.
- Reset is taken mid-count, with no partial update of any register.

## Test plan
- Reset/default: hold zera_n=0 for 2 cycles with conta=1, then release; count 100 edges up with M=100.
  - During reset: Q=0, m_atual=100.
  - meio at Q=49, quarto at Q=24, fim at Q=99.
  - On the edge after Q=99: Q=0 and estouro=1 for one cycle.
- Down/wrap vs saturate: with m_atual=10, Q=0, desce=1, conta=1:
  - satura=0: next Q=9, estouro pulse.
  - satura=1: Q stays 0, estouro stays 1 while conta=1.
  - Lowering conta drops estouro the next cycle.
- Modulus change: with Q=7, pulse define_m with modulo=5, giving Q=0 and m_atual=5.
  - modulo=1 gives m_atual=2.
  - modulo=2^N+5 gives m_atual=2^N.
  - modulo=3: quarto stays 0.
- Load clamp: with m_atual=20, carrega with dado=30 gives Q=19 and fim=1.
  - carrega+define_m together with modulo=8, dado=12 gives Q=7, m_atual=8.
  - conta=1 in the same cycle has no effect.
- Priority: zera_s=1 with carrega=1, conta=1, define_m=1, modulo=6 gives Q=0, m_atual=6, estouro=0.
  - zera_n=0 during the same stimulus gives m_atual=M.
- Full range: N=4, M=16; count up 16 edges. Q goes 0..15 then 0, with a single estouro pulse.
